gpio_mirror_master: RTL and testbench
=====================================

Name: gpio_mirror_master

Overview:
- Wishbone initiator that drives the team's 16-bit GPIO switch/LED slave from the master side.
- On each enabled tick rising edge it reads the switch register. When the value changes, it writes that value (optionally XOR-masked) to the LED register.
- Wishbone handshakes are bounded by a timeout counter. Captured switch state and a change pulse are exported to the rest of the SoC.

Parameters:
- ADR_W, 1, width of wb_adr_o.
- SW_ADR, 0, address of the switch register (read).
- LED_ADR, 1, address of the LED register (write).
- LED_XOR, 16'h0000, mask XORed into the captured switch value to form the LED write data.
- TIMEOUT, 15, maximum cycles with stb asserted before the transfer is abandoned; legal range 1..255.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-low (0 = reset).
- wb_adr_o  out  ADR_W  Wishbone address.
- wb_dat_o  out  16  write data.
- wb_dat_i  in  16  read data.
- wb_sel_o  out  2  byte selects; always 2'b11 while cyc is high, 2'b00 otherwise.
- wb_we_o  out  1  write enable.
- wb_stb_o  out  1  strobe.
- wb_cyc_o  out  1  cycle.
- wb_ack_i  in  1  acknowledge; may be combinational in the same cycle as stb.
- tick  in  1  poll request, level signal; only its rising edge is used.
- enable  in  1  polling enable.
- sw_val  out  16  last successfully read switch value.
- sw_chg  out  1  one-cycle pulse when sw_val is updated with a new value.
- bus_err  out  1  sticky timeout flag.
- busy  out  1  high while cyc is asserted.

Behaviour:
- Reset: all outputs are 0, state IDLE, tick_old=0, first_flag=1. sw_val=0, bus_err=0.
- All Wishbone outputs are registered. ack is sampled only when stb=1.
- FSM states: IDLE, RD, WR.
- IDLE -> RD: taken on the cycle after a tick rising edge (tick & ~tick_old) with enable=1.
  - Registers set: cyc=stb=1, we=0, adr=SW_ADR, tmo=0.
- A tick edge seen while not in IDLE, or while enable=0, is discarded. It is not queued.
- RD with ack=1: sw_val <= wb_dat_i.
  - If wb_dat_i != sw_val or first_flag=1: sw_chg pulses for one cycle and first_flag <= 0. Then enter WR with we=1, adr=LED_ADR, dat_o = wb_dat_i ^ LED_XOR, tmo=0.
  - Otherwise: drop cyc/stb and return to IDLE.
- WR with ack=1: drop cyc/stb/we and return to IDLE.
- A successful ack in RD or WR clears bus_err.
- Zero-wait slave timing: a poll with change takes 2 bus cycles. cyc deasserts for 0 cycles between RD and WR; cyc stays high and adr/we change on the same edge.
- Timeout: tmo increments every cycle in RD/WR without ack. When tmo==TIMEOUT-1 with no ack, the next edge does the following:
  - cyc/stb/we drop, bus_err <= 1, return to IDLE.
  - sw_val is unchanged and no LED write is issued.
  - A timed-out RD does not clear first_flag.
- ack arriving on the same cycle as the timeout terminal count: ack wins and the transfer completes normally.
- Deasserting enable mid-transfer does not abort; the current RD/WR (and a pending WR) completes.
- Asynchronous reset mid-transfer: cyc/stb drop immediately and the FSM returns to IDLE.
- wb_dat_o holds its last value when idle. It is only meaningful when we=1.
- busy == wb_cyc_o.

Decomposition:
- Shared package gpio_pkg:
  - State encoding: IDLE=2'd0, RD=2'd1, WR=2'd2.
  - GPIO_SW_ADR=0, GPIO_LED_ADR=1, GPIO_DW=16, GPIO_SEL_ALL=2'b11.
  - The slave uses the same address constants.
- One natural sub-module: wb_timeout_cnt, an 8-bit up-counter with clear/enable and a terminal-count output compared against TIMEOUT-1. It is reusable by other initiators.

Test Plan:
- Zero-wait slave returning 16'hA5A5 after reset, single tick pulse:
  - RD at adr=0 for 1 cycle, then WR at adr=1 with dat_o=16'hA5A5 for 1 cycle.
  - sw_val=16'hA5A5, sw_chg one pulse, bus_err=0.
- Second tick with the switch still 16'hA5A5:
  - RD only, no WR, no sw_chg.
  - Then the switch is changed to 16'h0003 and tick is pulsed: WR dat_o=16'h0003 and sw_chg pulses.
- LED_XOR=16'hFFFF, switch 16'h00F0:
  - LED write data is 16'hFF0F; sw_val=16'h00F0.
- Slave never acks, TIMEOUT=15:
  - stb stays high for exactly 15 cycles, then cyc=0 and bus_err=1.
  - sw_val is unchanged. The next successful poll clears bus_err.
- Slave acks on the 15th stb cycle (terminal count):
  - The transfer completes and bus_err stays 0.
  - A tick held high across the transfer, with a second rising edge arriving while busy, is discarded: exactly one RD occurs.
- Reset and enable:
  - wb_rst_i is pulled to 0 mid-RD: cyc/stb go to 0 immediately and sw_val=0. After release, the first poll with value 16'h0000 still issues a WR (first_flag).
  - With enable=0, tick edges produce no bus activity.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO switch/LED block: register map, bus width and
// the mirror initiator's state encoding.
package gpio_pkg;
    localparam int          GPIO_DW      = 16;
    localparam int          GPIO_SW_ADR  = 0;
    localparam int          GPIO_LED_ADR = 1;
    localparam logic [1:0]  GPIO_SEL_ALL = 2'b11;

    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_RD   = 2'd1;
    localparam logic [1:0]  ST_WR   = 2'd2;

    typedef logic [GPIO_DW-1:0] gpio_word_t;
endpackage

// File: rtl/gpio_mirror_master_if.sv
// Wishbone bundle between the GPIO mirror initiator and the GPIO slave.
// Signal names keep the initiator's point of view (_o driven by the master).
interface gpio_mirror_master_if #(parameter int ADR_W = 1);
    import gpio_pkg::*;

    logic [ADR_W-1:0] wb_adr_o;
    gpio_word_t       wb_dat_o;
    gpio_word_t       wb_dat_i;
    logic [1:0]       wb_sel_o;
    logic             wb_we_o;
    logic             wb_stb_o;
    logic             wb_cyc_o;
    logic             wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/wb_timeout_cnt.sv
// 8-bit handshake watchdog: counts while enabled, clears on request and flags
// the last cycle before a transfer must be abandoned (count == TIMEOUT-1).
module wb_timeout_cnt #(
    parameter int TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    logic [7:0] cnt_q, cnt_d;

    // Clear has priority so a new phase always starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = 8'd0;
        else if (en_i) cnt_d = cnt_q + 8'd1;
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= 8'd0;
        else         cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == 8'(TIMEOUT - 1));
endmodule

// File: rtl/gpio_mirror_master.sv
// Polls the GPIO switch register on each enabled tick rising edge and mirrors
// any new value (XOR-masked) into the LED register over Wishbone.
module gpio_mirror_master
    import gpio_pkg::*;
#(
    parameter int         ADR_W   = 1,
    parameter int         SW_ADR  = GPIO_SW_ADR,
    parameter int         LED_ADR = GPIO_LED_ADR,
    parameter gpio_word_t LED_XOR = 16'h0000,
    parameter int         TIMEOUT = 15
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    gpio_mirror_master_if.master wb,
    input  logic                 tick,
    input  logic                 enable,
    output gpio_word_t           sw_val,
    output logic                 sw_chg,
    output logic                 bus_err,
    output logic                 busy
);
    logic [1:0]       state_q, state_d;
    logic             cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    gpio_word_t       dat_q, dat_d, sw_val_q, sw_val_d;
    logic [1:0]       sel_q, sel_d;
    logic             sw_chg_q, sw_chg_d, bus_err_q, bus_err_d;
    logic             first_q, first_d, tick_old_q, tick_old_d;
    logic             ack_ok, tick_rise, tmo_tc;

    // ack only counts while a strobe is out; a late ack after abort is ignored.
    assign ack_ok    = stb_q & wb.wb_ack_i;
    assign tick_rise = tick & ~tick_old_q;

    wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk_i  (wb_clk_i),
        .rst_ni (wb_rst_i),
        .clr_i  (~cyc_q | ack_ok),
        .en_i   (cyc_q),
        .tc_o   (tmo_tc)
    );

    // Poll FSM: ack beats the watchdog when both land on the same cycle.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        sw_val_d   = sw_val_q;
        sw_chg_d   = 1'b0;
        bus_err_d  = bus_err_q;
        first_d    = first_q;
        tick_old_d = tick;
        case (state_q)
            ST_IDLE: begin
                if (tick_rise && enable) begin
                    state_d = ST_RD;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = 1'b0;
                    adr_d   = ADR_W'(SW_ADR);
                end
            end
            ST_RD: begin
                if (ack_ok) begin
                    sw_val_d  = wb.wb_dat_i;
                    bus_err_d = 1'b0;
                    if (wb.wb_dat_i != sw_val_q || first_q) begin
                        // Back-to-back write: cyc stays high, adr/we switch.
                        sw_chg_d = 1'b1;
                        first_d  = 1'b0;
                        state_d  = ST_WR;
                        we_d     = 1'b1;
                        adr_d    = ADR_W'(LED_ADR);
                        dat_d    = wb.wb_dat_i ^ LED_XOR;
                    end else begin
                        state_d = ST_IDLE;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                    end
                end else if (tmo_tc) begin
                    state_d   = ST_IDLE;
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    we_d      = 1'b0;
                    bus_err_d = 1'b1;
                end
            end
            ST_WR: begin
                if (ack_ok || tmo_tc) begin
                    state_d   = ST_IDLE;
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    we_d      = 1'b0;
                    bus_err_d = ~ack_ok;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
        sel_d = cyc_d ? GPIO_SEL_ALL : 2'b00;
    end

    // State and registered bus outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q    <= ST_IDLE;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= 2'b00;
            sw_val_q   <= '0;
            sw_chg_q   <= 1'b0;
            bus_err_q  <= 1'b0;
            first_q    <= 1'b1;
            tick_old_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            sw_val_q   <= sw_val_d;
            sw_chg_q   <= sw_chg_d;
            bus_err_q  <= bus_err_d;
            first_q    <= first_d;
            tick_old_q <= tick_old_d;
        end
    end

    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = sel_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_stb_o = stb_q;
    assign wb.wb_cyc_o = cyc_q;
    assign sw_val      = sw_val_q;
    assign sw_chg      = sw_chg_q;
    assign bus_err     = bus_err_q;
    assign busy        = cyc_q;
endmodule

// File: tb/tb_gpio_mirror_master.sv
// Bench for gpio_mirror_master: two instances (plain and LED_XOR=FFFF) share
// tick/enable/switch value; per-poll results are compared with a poll-level model.
module tb_gpio_mirror_master;
    import gpio_pkg::*;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] sw_in = 16'h0000;
    int          ack_mode = 0;   // 0: zero-wait, 1: never ack, 2: ack on 15th stb cycle
    int          stb_run = 0;

    logic [15:0] sw_val0, sw_val1;
    logic        chg0, chg1, err0, err1, busy0, busy1;

    always #5 clk = ~clk;

    gpio_mirror_master_if #(.ADR_W(1)) bus0 ();
    gpio_mirror_master_if #(.ADR_W(1)) bus1 ();

    gpio_mirror_master #(.ADR_W(1), .SW_ADR(0), .LED_ADR(1), .LED_XOR(16'h0000), .TIMEOUT(TMO)) dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .wb(bus0.master), .tick(tick), .enable(enable),
        .sw_val(sw_val0), .sw_chg(chg0), .bus_err(err0), .busy(busy0));

    gpio_mirror_master #(.ADR_W(1), .SW_ADR(0), .LED_ADR(1), .LED_XOR(16'hFFFF), .TIMEOUT(TMO)) dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .wb(bus1.master), .tick(tick), .enable(enable),
        .sw_val(sw_val1), .sw_chg(chg1), .bus_err(err1), .busy(busy1));

    // Slave models: dut0 has a configurable ack, dut1 is always zero-wait.
    assign bus0.wb_dat_i = sw_in;
    assign bus0.wb_ack_i = bus0.wb_stb_o && (ack_mode == 0 || (ack_mode == 2 && stb_run == TMO - 1));
    assign bus1.wb_dat_i = sw_in;
    assign bus1.wb_ack_i = bus1.wb_stb_o;

    always @(posedge clk) stb_run <= (bus0.wb_stb_o && !bus0.wb_ack_i) ? stb_run + 1 : 0;

    // Bus monitor: cumulative counters sampled mid-cycle.
    int          n_rd = 0, n_wr = 0, n_stb = 0, n_chg = 0, n_bad = 0, n_wr1 = 0, n_chg1 = 0;
    logic [15:0] last_wr = 16'h0, last_wr1 = 16'h0;

    always @(negedge clk) begin
        if (bus0.wb_stb_o) n_stb <= n_stb + 1;
        if (bus0.wb_stb_o && bus0.wb_ack_i && !bus0.wb_we_o) n_rd <= n_rd + 1;
        if (bus0.wb_stb_o && bus0.wb_ack_i && bus0.wb_we_o) begin
            n_wr    <= n_wr + 1;
            last_wr <= bus0.wb_dat_o;
        end
        if (chg0) n_chg <= n_chg + 1;
        if (bus1.wb_stb_o && bus1.wb_ack_i && bus1.wb_we_o) begin
            n_wr1    <= n_wr1 + 1;
            last_wr1 <= bus1.wb_dat_o;
        end
        if (chg1) n_chg1 <= n_chg1 + 1;
        if (bus0.wb_sel_o != (bus0.wb_cyc_o ? 2'b11 : 2'b00) || busy0 != bus0.wb_cyc_o ||
            (bus0.wb_stb_o && !bus0.wb_cyc_o) ||
            (bus0.wb_stb_o && bus0.wb_adr_o != (bus0.wb_we_o ? 1'b1 : 1'b0)) ||
            bus1.wb_sel_o != (bus1.wb_cyc_o ? 2'b11 : 2'b00) || busy1 != bus1.wb_cyc_o)
            n_bad <= n_bad + 1;
    end

    // Poll-level reference model.
    int          n_assert = 0, n_fail = 0;
    logic [15:0] m_val = 16'h0, m1_val = 16'h0;
    logic        m_first = 1'b1, m1_first = 1'b1, m_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80; i++) begin
            if (!busy0) break;
            @(negedge clk);
        end
        chk("idle_timeout", busy0, 0);
    endtask

    task automatic poll(input logic [15:0] sw, input int mode, input bit hold);
        int   rd0, wr0, stb0, c0, wr10, c10, exp_stb;
        logic rd_ok, change, change1;
        sw_in    = sw;
        ack_mode = mode;
        @(negedge clk);
        rd0 = n_rd; wr0 = n_wr; stb0 = n_stb; c0 = n_chg; wr10 = n_wr1; c10 = n_chg1;
        tick = 1'b1;
        if (hold) begin
            repeat (3) @(negedge clk);
            tick = 1'b0;
            @(negedge clk);
            tick = 1'b1;   // second rising edge while busy
            wait_idle();
            repeat (20) @(negedge clk);
            tick = 1'b0;
        end else begin
            @(negedge clk);
            tick = 1'b0;
            wait_idle();
        end
        @(negedge clk);
        rd_ok   = enable && mode != 1;
        change  = rd_ok && (sw != m_val || m_first);
        change1 = enable && (sw != m1_val || m1_first);
        if (!enable)        exp_stb = 0;
        else if (mode == 0) exp_stb = change ? 2 : 1;
        else if (mode == 1) exp_stb = TMO;
        else                exp_stb = change ? 2 * TMO : TMO;
        chk("rd_acks", n_rd - rd0, rd_ok);
        chk("wr_acks", n_wr - wr0, change);
        if (change) chk("wr_data", last_wr, sw);
        chk("chg_pulses", n_chg - c0, change);
        chk("stb_cycles", n_stb - stb0, exp_stb);
        chk("wr_acks_xor", n_wr1 - wr10, change1);
        if (change1) chk("wr_data_xor", last_wr1, sw ^ 16'hFFFF);
        chk("chg_pulses_xor", n_chg1 - c10, change1);
        if (enable) begin
            if (rd_ok) begin
                m_err = 1'b0;
                if (change) begin m_val = sw; m_first = 1'b0; end
            end else begin
                m_err = 1'b1;
            end
            if (change1) begin m1_val = sw; m1_first = 1'b0; end
        end
        chk("sw_val", sw_val0, m_val);
        chk("bus_err", err0, m_err);
        chk("sw_val_xor", sw_val1, m1_val);
    endtask

    initial begin
        logic [15:0] pool [4];
        int          r;
        pool[0] = 16'hA5A5; pool[1] = 16'h0003; pool[2] = 16'h00F0; pool[3] = 16'h8001;

        // Reset state
        #12;
        chk("rst_cyc", bus0.wb_cyc_o, 0);
        chk("rst_stb", bus0.wb_stb_o, 0);
        chk("rst_we", bus0.wb_we_o, 0);
        chk("rst_sel", bus0.wb_sel_o, 0);
        chk("rst_adr", bus0.wb_adr_o, 0);
        chk("rst_dat", bus0.wb_dat_o, 0);
        chk("rst_sw_val", sw_val0, 0);
        chk("rst_chg", chg0, 0);
        chk("rst_err", err0, 0);
        chk("rst_busy", busy0, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);

        poll(16'hA5A5, 0, 0);   // first poll writes
        poll(16'hA5A5, 0, 0);   // unchanged: read only
        poll(16'h0003, 0, 0);   // changed: write
        poll(16'h00F0, 0, 0);   // XOR instance writes FF0F
        chk("xor_led_data", last_wr1, 16'hFF0F);
        poll(16'h1111, 1, 0);   // timeout
        chk("tmo_err", err0, 1);
        chk("tmo_sw_val", sw_val0, 16'h00F0);
        poll(16'h1111, 0, 0);   // success clears bus_err
        chk("err_cleared", err0, 0);
        poll(16'h2222, 2, 1);   // ack at terminal count, re-edge while busy

        enable = 1'b0;
        poll(16'h7777, 0, 0);   // no bus activity
        enable = 1'b1;

        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(0, 5);
            poll(pool[$urandom_range(0, 3)], (r < 4) ? 0 : (r == 4 ? 2 : 1), 0);
        end

        // Reset during a stalled read
        sw_in    = 16'h1234;
        ack_mode = 1;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rd_busy", busy0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cyc", bus0.wb_cyc_o, 0);
        chk("arst_stb", bus0.wb_stb_o, 0);
        chk("arst_sw_val", sw_val0, 0);
        chk("arst_busy", busy0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_val = 16'h0; m_first = 1'b1; m_err = 1'b0;
        m1_val = 16'h0; m1_first = 1'b1;
        poll(16'h0000, 0, 0);   // first_flag forces a write of 0000

        chk("protocol_bad", n_bad, 0);
        chk("err_xor", err1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
